rv_decode_execute: RTL and testbench

// - RV32IM-subset decode/execute stage for the single-issue 2-stage CPU: splits the

---
 rtl/rv_decode_execute.sv | 214 +++++++++++++++++++++
 tb/tb_rv_decode_execute.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_execute.sv
// Decode/execute stage of the 2-stage RV32IM-subset core: field split, control, ALU,
// and the EX/WB pipeline register feeding the regfile write port.
module rv_decode_execute (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [31:0] readdata1,
    input  logic [31:0] readdata2,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        gpio_we,
    output logic        zero,
    output logic [31:0] r_wb,
    output logic [31:0] imm20_wb,
    output logic [4:0]  rd_wb,
    output logic        regwrite_wb,
    output logic [1:0]  regsel_wb
);

    localparam logic [3:0] AluAnd   = 4'b0000;
    localparam logic [3:0] AluOr    = 4'b0001;
    localparam logic [3:0] AluXor   = 4'b0010;
    localparam logic [3:0] AluAdd   = 4'b0011;
    localparam logic [3:0] AluSub   = 4'b0100;
    localparam logic [3:0] AluMul   = 4'b0101;
    localparam logic [3:0] AluMulh  = 4'b0110;
    localparam logic [3:0] AluMulhu = 4'b0111;
    localparam logic [3:0] AluSll   = 4'b1000;
    localparam logic [3:0] AluSrl   = 4'b1001;
    localparam logic [3:0] AluSra   = 4'b1010;
    localparam logic [3:0] AluSlt   = 4'b1100;
    localparam logic [3:0] AluSltu  = 4'b1101;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpSystem = 7'b1110011;

    localparam logic [1:0] SelGpio = 2'b00;
    localparam logic [1:0] SelImm  = 2'b01;
    localparam logic [1:0] SelAlu  = 2'b10;

    localparam logic [11:0] CsrGpioIn  = 12'hF00;
    localparam logic [11:0] CsrGpioOut = 12'hF02;

    // ---------------- decoder ----------------
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm12;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm12  = instruction[31:20];

    // ---------------- control_unit ----------------
    logic [3:0] aluop;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] regsel;

    // Shared funct3 map of the base integer ops; alt selects SRA over SRL.
    function automatic logic [3:0] base_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    always_comb begin
        aluop    = AluAdd;
        alusrc   = 1'b0;
        regwrite = 1'b0;
        regsel   = SelAlu;
        gpio_we  = 1'b0;
        case (opcode)
            OpR: begin
                case (funct7)
                    7'b0000000: begin
                        aluop    = base_op(funct3, 1'b0);
                        regwrite = 1'b1;
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000) begin
                            aluop    = AluSub;
                            regwrite = 1'b1;
                        end else if (funct3 == 3'b101) begin
                            aluop    = AluSra;
                            regwrite = 1'b1;
                        end
                    end
                    7'b0000001: begin
                        case (funct3)
                            3'b000: begin
                                aluop    = AluMul;
                                regwrite = 1'b1;
                            end
                            3'b001: begin
                                aluop    = AluMulh;
                                regwrite = 1'b1;
                            end
                            3'b011: begin
                                aluop    = AluMulhu;
                                regwrite = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            OpI: begin
                aluop    = base_op(funct3, instruction[30]);
                alusrc   = 1'b1;
                regwrite = 1'b1;
            end
            OpLui: begin
                regwrite = 1'b1;
                regsel   = SelImm;
            end
            OpSystem: begin
                if (funct3 == 3'b001) begin
                    if (imm12 == CsrGpioIn) begin
                        regwrite = 1'b1;
                        regsel   = SelGpio;
                    end else if (imm12 == CsrGpioOut) begin
                        gpio_we = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------- operand B ----------------
    logic        shift_op;
    logic [31:0] op_a;
    logic [31:0] op_b;

    assign shift_op = (aluop == AluSll) || (aluop == AluSrl) || (aluop == AluSra);
    assign op_a     = readdata1;

    always_comb begin
        if (!alusrc) begin
            op_b = readdata2;
        end else if (shift_op) begin
            op_b = {27'b0, imm12[4:0]};
        end else begin
            op_b = {{20{imm12[11]}}, imm12};
        end
    end

    // ---------------- alu ----------------
    logic signed [63:0] prod_ss;
    logic        [31:0] hi_u;
    logic        [31:0] alu_r;

    assign prod_ss = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
    // Unsigned high word recovered from the signed product, saving a second multiplier.
    assign hi_u = prod_ss[63:32] + (op_a[31] ? op_b : 32'd0) + (op_b[31] ? op_a : 32'd0);

    always_comb begin
        alu_r = 32'd0;
        case (aluop)
            AluAnd:   alu_r = op_a & op_b;
            AluOr:    alu_r = op_a | op_b;
            AluXor:   alu_r = op_a ^ op_b;
            AluAdd:   alu_r = op_a + op_b;
            AluSub:   alu_r = op_a - op_b;
            AluMul:   alu_r = prod_ss[31:0];
            AluMulh:  alu_r = prod_ss[63:32];
            AluMulhu: alu_r = hi_u;
            AluSll:   alu_r = op_a << op_b[4:0];
            AluSrl:   alu_r = op_a >> op_b[4:0];
            AluSra:   alu_r = $signed(op_a) >>> op_b[4:0];
            AluSlt:   alu_r = {31'b0, $signed(op_a) < $signed(op_b)};
            AluSltu:  alu_r = {31'b0, op_a < op_b};
            default:  alu_r = 32'd0;
        endcase
    end

    assign zero = (alu_r == 32'd0);

    // ---------------- EX/WB register ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb        <= 32'd0;
            imm20_wb    <= 32'd0;
            rd_wb       <= 5'd0;
            regwrite_wb <= 1'b0;
            regsel_wb   <= 2'b00;
        end else begin
            r_wb        <= alu_r;
            imm20_wb    <= {instruction[31:12], 12'b0};
            rd_wb       <= rd;
            regwrite_wb <= regwrite && (rd != 5'd0);
            regsel_wb   <= regsel;
        end
    end

endmodule

// File: tb/tb_rv_decode_execute.sv
// Directed bench for rv_decode_execute: hand-encoded instructions with hand-computed results.
module tb_rv_decode_execute;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic [31:0] readdata1;
    logic [31:0] readdata2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        gpio_we;
    logic        zero;
    logic [31:0] r_wb;
    logic [31:0] imm20_wb;
    logic [4:0]  rd_wb;
    logic        regwrite_wb;
    logic [1:0]  regsel_wb;

    int n_tests = 0;
    int n_fail  = 0;

    rv_decode_execute dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .readdata1   (readdata1),
        .readdata2   (readdata2),
        .rs1         (rs1),
        .rs2         (rs2),
        .gpio_we     (gpio_we),
        .zero        (zero),
        .r_wb        (r_wb),
        .imm20_wb    (imm20_wb),
        .rd_wb       (rd_wb),
        .regwrite_wb (regwrite_wb),
        .regsel_wb   (regsel_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive inputs away from the active edge, settle combinational outputs.
    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instruction = ins;
        readdata1   = a;
        readdata2   = b;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic [31:0] r, input logic [4:0] rd,
                            input logic we, input logic [1:0] sel);
        check({tag, ".r_wb"}, r_wb, r);
        check({tag, ".rd_wb"}, {27'b0, rd_wb}, {27'b0, rd});
        check({tag, ".regwrite_wb"}, {31'b0, regwrite_wb}, {31'b0, we});
        check({tag, ".regsel_wb"}, {30'b0, regsel_wb}, {30'b0, sel});
    endtask

    initial begin
        rst         = 1'b0;
        instruction = 32'h0;
        readdata1   = 32'h0;
        readdata2   = 32'h0;
        repeat (2) step();
        check_wb("reset", 32'h0, 5'd0, 1'b0, 2'b00);
        check("reset.imm20_wb", imm20_wb, 32'h0);

        @(negedge clk);
        rst = 1'b1;

        // addi x5,x0,-3
        drive(32'hFFD00293, 32'h0, 32'h0);
        check("addi.rs1", {27'b0, rs1}, 32'd0);
        step();
        check_wb("addi", 32'hFFFFFFFD, 5'd5, 1'b1, 2'b10);
        check("addi.imm20_wb", imm20_wb, 32'hFFD00000);

        // lui x1,0x12345
        drive(32'h123450B7, 32'h0, 32'h0);
        step();
        check("lui.imm20_wb", imm20_wb, 32'h12345000);
        check("lui.regsel_wb", {30'b0, regsel_wb}, 32'd1);
        check("lui.rd_wb", {27'b0, rd_wb}, 32'd1);
        check("lui.regwrite_wb", {31'b0, regwrite_wb}, 32'd1);

        // srai x2,x1,4
        drive(32'h4040D113, 32'h80000000, 32'h0);
        step();
        check_wb("srai", 32'hF8000000, 5'd2, 1'b1, 2'b10);

        // mulhu x3,x1,x2
        drive(32'h0220B1B3, 32'hFFFFFFFF, 32'h2);
        check("mulhu.rs1", {27'b0, rs1}, 32'd1);
        check("mulhu.rs2", {27'b0, rs2}, 32'd2);
        step();
        check_wb("mulhu", 32'h00000001, 5'd3, 1'b1, 2'b10);

        // mul / mulh x5,x1,x2 with -1 * 3
        drive(32'h022082B3, 32'hFFFFFFFF, 32'h3);
        step();
        check("mul.r_wb", r_wb, 32'hFFFFFFFD);
        drive(32'h022092B3, 32'hFFFFFFFF, 32'h3);
        step();
        check("mulh.r_wb", r_wb, 32'hFFFFFFFF);

        // sub x3,x1,x2: equal operands then differing
        drive(32'h402081B3, 32'h1234, 32'h1234);
        check("sub_eq.zero", {31'b0, zero}, 32'd1);
        drive(32'h402081B3, 32'h1234, 32'h1233);
        check("sub_ne.zero", {31'b0, zero}, 32'd0);
        step();
        check("sub.r_wb", r_wb, 32'h1);

        // slt / sltu x5,x1,x2 with -1 vs 1
        drive(32'h0020A2B3, 32'hFFFFFFFF, 32'h1);
        step();
        check("slt.r_wb", r_wb, 32'h1);
        drive(32'h0020B2B3, 32'hFFFFFFFF, 32'h1);
        step();
        check("sltu.r_wb", r_wb, 32'h0);

        // slli x5,x1,31: shift amount is the zero-extended imm[4:0]
        drive(32'h01F09293, 32'h1, 32'h0);
        step();
        check("slli.r_wb", r_wb, 32'h80000000);

        // andi x5,x1,-16: sign-extended immediate
        drive(32'hFF00F293, 32'h12345678, 32'h0);
        step();
        check("andi.r_wb", r_wb, 32'h12345670);

        // csrrw x0,0xF02,x7
        drive(32'hF0239073, 32'hA5, 32'h0);
        check("csr_out.gpio_we", {31'b0, gpio_we}, 32'd1);
        step();
        check("csr_out.regwrite_wb", {31'b0, regwrite_wb}, 32'd0);

        // csrrw x4,0xF00,x7
        drive(32'hF0039273, 32'h0, 32'h0);
        check("csr_in.gpio_we", {31'b0, gpio_we}, 32'd0);
        step();
        check("csr_in.regsel_wb", {30'b0, regsel_wb}, 32'd0);
        check("csr_in.regwrite_wb", {31'b0, regwrite_wb}, 32'd1);
        check("csr_in.rd_wb", {27'b0, rd_wb}, 32'd4);

        // add x0,x1,x2: x0 is never written
        drive(32'h00208033, 32'h10, 32'h20);
        step();
        check("add_x0.r_wb", r_wb, 32'h30);
        check("add_x0.regwrite_wb", {31'b0, regwrite_wb}, 32'd0);

        // Illegal opcode and unlisted R-type funct fall back to a non-writing add
        drive(32'h00000000, 32'h7, 32'h8);
        step();
        check_wb("illegal", 32'hF, 5'd0, 1'b0, 2'b10);
        drive(32'h402092B3, 32'h7, 32'h8);
        step();
        check_wb("bad_funct", 32'hF, 5'd5, 1'b0, 2'b10);

        // add x5,x1,x2 under reset, then released
        drive(32'h002082B3, 32'h100, 32'h23);
        rst = 1'b0;
        step();
        check_wb("rst_hold", 32'h0, 5'd0, 1'b0, 2'b00);
        check("rst_hold.imm20_wb", imm20_wb, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_wb("rst_release", 32'h123, 5'd5, 1'b1, 2'b10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
